// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

    // Number of words the skid buffer can hold.
    localparam int unsigned BUF_ENTRIES = 2;

    // Occupancy of the skid buffer; the encoding equals the word count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_stream_reader_skid_buf2.sv
// Two-entry skid buffer: push to tail, pop from head, head data and occupancy out.
// A clear empties the buffer and wins over a simultaneous push or pop.
module skid_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] head_data_o,
    output logic [1:0]       occ_o
);

    occ_e             occ_q;
    logic [Width-1:0] head_q;
    logic [Width-1:0] tail_q;

    // Occupancy FSM and storage: push fills the tail, pop advances the head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q  <= EMPTY;
            head_q <= '0;
            tail_q <= '0;
        end else if (clear_i) begin
            occ_q <= EMPTY;
        end else begin
            case (occ_q)
                EMPTY: begin
                    // No bypass: a word pushed into an empty buffer is visible next cycle.
                    if (push_i) begin
                        head_q <= push_data_i;
                        occ_q  <= ONE;
                    end
                end
                ONE: begin
                    if (push_i && pop_i) begin
                        head_q <= push_data_i;
                    end else if (push_i) begin
                        tail_q <= push_data_i;
                        occ_q  <= TWO;
                    end else if (pop_i) begin
                        occ_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (pop_i) begin
                        head_q <= tail_q;
                        if (push_i) begin
                            tail_q <= push_data_i;
                        end else begin
                            occ_q <= ONE;
                        end
                    end
                end
                default: occ_q <= EMPTY;
            endcase
        end
    end

    assign head_data_o = head_q;
    assign occ_o       = occ_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO (registered read data) into a valid/ready stream
// through a 2-entry skid buffer, sustaining one word per cycle.
// Optional feature: define FIFO_RD_STATS_EN to add the rd_count transfer counter.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             fifo_empty,
    input  logic [Width-1:0] fifo_dout,
    output logic             fifo_r_enb,
    output logic             m_valid,
    output logic [Width-1:0] m_data,
    input  logic             m_ready
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [15:0]      rd_count
`endif
);

    logic       infl_q;
    logic [1:0] occ;
    logic       xfer;
    logic       push;
    logic [2:0] pending;

    // Read only when the buffered, in-flight and leaving words leave room for one more.
    always_comb begin
        xfer       = m_valid && m_ready;
        pending    = {1'b0, occ} + {2'b00, infl_q} - {2'b00, xfer};
        fifo_r_enb = !reset && !fifo_empty && !flush && (pending < 3'(BUF_ENTRIES));
        push       = infl_q && !flush;
    end

    // In-flight flag: the FIFO presents the word read last cycle on fifo_dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            infl_q <= 1'b0;
        end else begin
            infl_q <= fifo_r_enb;
        end
    end

    skid_buf2 #(
        .Width (Width)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (flush),
        .push_i      (push),
        .push_data_i (fifo_dout),
        .pop_i       (xfer),
        .head_data_o (m_data),
        .occ_o       (occ)
    );

    assign m_valid = (occ != EMPTY);

`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count_q;

    // Transfer counter since reset or flush; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
        end else if (flush) begin
            rd_count_q <= '0;
        end else if (xfer) begin
            rd_count_q <= rd_count_q + 16'd1;
        end
    end

    assign rd_count = rd_count_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: behavioural FIFO source, a queue
// scoreboard of issued-but-undelivered words, directed sequences and random traffic.
module tb_fifo_stream_reader;

    localparam int unsigned Width = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        m_ready;
    logic        fifo_empty;
    logic [15:0] fifo_dout = '0;
    logic        fifo_r_enb;
    logic        m_valid;
    logic [15:0] m_data;
`ifdef FIFO_RD_STATS_EN
    logic [15:0] rd_count;
`endif

    always #5 clk = ~clk;

    // Behavioural FIFO source: mem filled by the test, drained on r_enb.
    logic [15:0] mem [256];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;
    logic        src_inf = 1'b0;

    function automatic logic [15:0] word_at(input int unsigned p);
        return src_inf ? p[15:0] : mem[p[7:0]];
    endfunction

    assign fifo_empty = !src_inf && (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_r_enb) begin
            fifo_dout <= word_at(rd_ptr);
            rd_ptr    <= rd_ptr + 1;
        end
    end

    fifo_stream_reader #(
        .Width (Width)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_r_enb (fifo_r_enb),
        .m_valid    (m_valid),
        .m_data     (m_data),
        .m_ready    (m_ready)
`ifdef FIFO_RD_STATS_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input logic ok, input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Scoreboard: words read from the FIFO and not yet delivered, in order.
    logic [15:0] exp_q [$];
    logic [15:0] got_q [$];
    int          xfers     = 0;
    int          rd_issued = 0;
    logic        hold_prev = 1'b0;
    logic [15:0] hold_data = '0;

    task automatic load(input logic [15:0] w);
        mem[wr_ptr[7:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    // One clock: model and check at negedge, then return 1ns after posedge.
    task automatic cyc();
        @(negedge clk);
        if (reset) begin
            check({m_valid, fifo_r_enb, m_data} == 18'h0, "reset_hold",
                  {14'h0, m_valid, fifo_r_enb, m_data}, 32'h0);
            exp_q.delete();
            hold_prev = 1'b0;
            xfers     = 0;
        end else begin
            if (hold_prev)
                check(m_valid && (m_data == hold_data), "stall_stable", {15'h0, m_valid, m_data},
                      {16'h1, hold_data});
            if (flush) check(!fifo_r_enb, "flush_no_read", fifo_r_enb, 0);
            if (m_valid && m_ready) begin
                check(exp_q.size() != 0, "word_expected", exp_q.size(), 1);
                if (exp_q.size() != 0) begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    check(m_data == e, "order", m_data, e);
                end
                got_q.push_back(m_data);
                if (!flush) xfers++;
            end
            if (flush) begin
                exp_q.delete();
                xfers = 0;
            end
            if (fifo_r_enb) begin
                exp_q.push_back(word_at(rd_ptr));
                rd_issued++;
            end
            check(exp_q.size() <= 2, "occupancy", exp_q.size(), 2);
            hold_prev = !flush && m_valid && !m_ready;
            hold_data = m_data;
        end
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        ready;
        logic        r_enb;
        logic        valid;
        logic [15:0] data;
        logic        chk_data;
    } vec_t;

    vec_t tbl [6];

    initial begin
        int n;
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h1111, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 1'b1, 16'h2222, 1'b1};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'h3333, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0};

        reset   = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;
        #1;
        cyc();
        load(16'h1111);
        load(16'h2222);
        load(16'h3333);
        cyc();
        cyc();

        // Reset release with A,B,C queued: read at cycle 0, words at cycles 2..4.
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            m_ready = tbl[i].ready;
            #1;
            check(fifo_r_enb == tbl[i].r_enb, $sformatf("release_renb_c%0d", i), fifo_r_enb,
                  tbl[i].r_enb);
            check(m_valid == tbl[i].valid, $sformatf("release_valid_c%0d", i), m_valid,
                  tbl[i].valid);
            if (tbl[i].chk_data)
                check(m_data == tbl[i].data, $sformatf("release_data_c%0d", i), m_data,
                      tbl[i].data);
            cyc();
        end

        // Stalled sink with 5 words: only two reads, head held.
        m_ready = 1'b0;
        rd_issued = 0;
        got_q.delete();
        for (int i = 0; i < 5; i++) load(16'h5000 + 16'(i));
        for (int i = 0; i < 8; i++) cyc();
        check(rd_issued == 2, "stall_reads", rd_issued, 2);
        check(m_valid && (m_data == 16'h5000), "stall_head", {15'h0, m_valid, m_data}, 32'h15000);
        m_ready = 1'b1;
        n = 0;
        while (got_q.size() < 5 && n < 40) begin cyc(); n++; end
        check(got_q.size() == 5, "stall_count", got_q.size(), 5);
        for (int i = 0; i < 5 && i < got_q.size(); i++)
            check(got_q[i] == 16'h5000 + 16'(i), "stall_drain", got_q[i], 16'h5000 + 16'(i));

        // Toggling ready: every word once, in order.
        got_q.delete();
        for (int i = 0; i < 4; i++) load(16'h6000 + 16'(i));
        n = 0;
        while (got_q.size() < 4 && n < 40) begin
            m_ready = (n % 2 == 0);
            cyc();
            n++;
        end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check(got_q.size() == 4, "toggle_count", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check(got_q[i] == 16'h6000 + 16'(i), "toggle_order", got_q[i], 16'h6000 + 16'(i));

        // Flush the cycle after a read: in-flight word dropped.
        for (int i = 0; i < 4; i++) load(16'h7000 + 16'(i));
        #1;
        check(fifo_r_enb == 1'b1, "flush_pre_read", fifo_r_enb, 1);
        cyc();
        flush = 1'b1;
        #1;
        check(fifo_r_enb == 1'b0, "flush_blocks_read", fifo_r_enb, 0);
        cyc();
        flush = 1'b0;
        check(m_valid == 1'b0, "flush_empty", m_valid, 0);
        got_q.delete();
        n = 0;
        while (got_q.size() < 3 && n < 20) begin cyc(); n++; end
        check(got_q.size() == 3, "flush_count", got_q.size(), 3);
        if (got_q.size() > 0) check(got_q[0] == 16'h7001, "flush_next", got_q[0], 16'h7001);

        // Async reset with the buffer full.
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) load(16'h8000 + 16'(i));
        for (int i = 0; i < 6; i++) cyc();
        check(m_valid == 1'b1, "full_before_reset", m_valid, 1);
        #2;
        reset = 1'b1;
        #1;
        check(!m_valid && (m_data == 16'h0), "async_reset", {15'h0, m_valid, m_data}, 0);
        cyc();
        cyc();
        reset   = 1'b0;
        m_ready = 1'b1;
        got_q.delete();
        n = 0;
        while (got_q.size() < 1 && n < 20) begin cyc(); n++; end
        check(got_q.size() == 1, "post_reset_count", got_q.size(), 1);
        if (got_q.size() > 0) check(got_q[0] == 16'h8002, "post_reset_word", got_q[0], 16'h8002);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            m_ready = ($urandom_range(0, 3) != 0);
            flush   = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 2) == 0 && (wr_ptr - rd_ptr) < 200) load(16'($urandom));
            cyc();
        end
        flush   = 1'b0;
        m_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || !fifo_empty) && n < 1000) begin cyc(); n++; end
        check(exp_q.size() == 0 && !m_valid, "random_drain", {exp_q.size(), m_valid}, 0);

`ifdef FIFO_RD_STATS_EN
        reset = 1'b1;
        cyc();
        check(rd_count == 16'h0, "rd_count_reset", rd_count, 0);
        reset   = 1'b0;
        src_inf = 1'b1;
        n = 0;
        while (xfers < 65537 && n < 70000) begin cyc(); n++; end
        m_ready = 1'b0;
        check(rd_count == 16'h1, "rd_count_wrap", rd_count, 1);
        flush = 1'b1;
        cyc();
        flush   = 1'b0;
        src_inf = 1'b0;
        wr_ptr  = rd_ptr;
        check(rd_count == 16'h0, "rd_count_flush", rd_count, 0);
        cyc();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_stream_reader.md
FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 SHALL have parameter Width, default 16: data word width, equal to the attached FIFO's Width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port flush  input  1  synchronous discard of all buffered and in-flight words.
REQ-005 SHALL have port fifo_empty  input  1  empty flag of the sync FIFO being drained.
REQ-006 SHALL have port fifo_dout  input  Width  registered FIFO read data, valid one cycle after an accepted read.
REQ-007 SHALL have port fifo_r_enb  output  1  FIFO read enable, combinational.
REQ-008 SHALL have port m_valid  output  1  stream word available, registered.
REQ-009 SHALL have port m_data  output  Width  stream word, registered; stable while m_valid && !m_ready.
REQ-010 SHALL have port m_ready  input  1  downstream accept; a transfer occurs when m_valid && m_ready.

Function
REQ-011 SHALL hold a 2-entry skid buffer; occupancy states EMPTY, ONE, TWO; m_valid = (state != EMPTY); m_data = head entry.
REQ-012 SHALL set in-flight flag infl on each posedge where fifo_r_enb was high, and clear it otherwise.
REQ-013 SHALL assert fifo_r_enb = !fifo_empty && !flush && (occ + infl - (m_valid && m_ready)) < 2, so the buffer never overflows.
REQ-014 SHALL capture fifo_dout into the buffer tail on the posedge where infl is high, unless it is dropped under REQ-018.
REQ-015 SHALL give a latency of 2 cycles: r_enb high in cycle N -> m_valid high in cycle N+2 with that word.
REQ-016 SHALL sustain one word per cycle when fifo_empty = 0 and m_ready = 1 are held continuously.
REQ-017 SHALL apply transitions as follows: capture only -> occ+1; transfer only -> occ-1; both -> occ unchanged, head advances. Simultaneous capture in EMPTY with m_ready is not bypassed.
REQ-018 flush SHALL set occ to EMPTY at the next posedge, drop any word whose infl is set that cycle, and hold fifo_r_enb at 0 while flush = 1.
REQ-019 SHALL preserve FIFO order exactly, with no duplication or loss except under flush.
REQ-020 SHALL leave m_valid and m_data unchanged while m_valid && !m_ready, except under flush.

Reset
REQ-021 While reset = 1, the block SHALL hold m_valid = 0, m_data = 0, occ = EMPTY and infl = 0; fifo_r_enb SHALL be 0.
REQ-022 Reset asserted mid-transfer SHALL discard buffered and in-flight words; the first read after release SHALL occur no earlier than the first posedge after deassertion.

Configuration
REQ-023 When macro FIFO_RD_STATS_EN is defined, the block SHALL add output rd_count [15:0]: transfers since reset or flush. It wraps 0xFFFF -> 0, resets to 0, and is cleared by flush.
REQ-024 When FIFO_RD_STATS_EN is undefined, the rd_count port and its logic SHALL be absent, with no other behavioural change.

Structure
REQ-025 The shared package SHALL hold the occupancy-state typedef (EMPTY/ONE/TWO) and the constant BUF_ENTRIES = 2.
REQ-026 The 2-entry buffer SHALL be one sub-module skid_buf2 (push, pop, head data, occupancy); control logic stays in the top module.

Verification
REQ-027 The bench SHALL cover: reset release with FIFO holding A,B,C and m_ready = 1 -> r_enb high cycle 0; A,B,C on m_data in cycles 2,3,4; no gaps.
REQ-028 The bench SHALL cover: m_ready = 0 with 5 words in the FIFO -> exactly 2 reads issued; m_valid = 1 with m_data = word0 held; then m_ready = 1 -> words 0..4 in order.
REQ-029 The bench SHALL cover: m_ready toggling 1,0,1,0 with 4 words -> every word delivered once, in order, and the buffer never exceeds 2.
REQ-030 The bench SHALL cover: flush in the cycle after r_enb -> in-flight word dropped, m_valid = 0 the next cycle, and the next word out is the FIFO's following entry.
REQ-031 The bench SHALL cover: reset asserted with occ = TWO -> m_valid = 0 and m_data = 0 immediately (asynchronous), then normal draining after release.
REQ-032 The bench SHALL cover, with FIFO_RD_STATS_EN defined: 65537 transfers -> rd_count = 1; a flush -> rd_count = 0.
